xsim_dma_arbiter: RTL

- Shares one simulated-DMA word port (single-word read request/response and write32 interface) among NUM_CLIENTS requesters.
- Accepts per-client read or write bursts, grants them round-robin, and sequences each burst into consecutive 32-bit word accesses at addr, addr+4, …
- Read data returns on one shared tagged stream. Sits between the xsim top-level test logic and the DMA bridge.

---
 rtl/xsim_dma_arb_pkg.sv | 13 +
 rtl/xsim_rr_arbiter.sv | 33 +++
 rtl/xsim_dma_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/xsim_dma_arb_pkg.sv
// rtl/xsim_dma_arb_pkg.sv - shared types and constants for the DMA word-port arbiter
package xsim_dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

  localparam int BEAT_BYTES = 4;
  localparam int DEF_LEN_W  = 4;

endpackage

// File: rtl/xsim_rr_arbiter.sv
// rtl/xsim_rr_arbiter.sv - combinational round-robin picker starting after rr_ptr
module xsim_rr_arbiter
  import xsim_dma_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CID_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [CID_W-1:0]       rr_ptr,
  output logic                   grant_valid,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [CID_W-1:0]       grant_idx
);

  logic [CID_W-1:0] cand;

  // Walk clients rr_ptr+1 .. rr_ptr+NUM_CLIENTS (wrapping) and keep the first requester.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      cand = CID_W'((int'(rr_ptr) + i) % NUM_CLIENTS);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xsim_dma_arbiter.sv
// rtl/xsim_dma_arbiter.sv - round-robin burst arbiter in front of the simulated DMA word port
module xsim_dma_arbiter
  import xsim_dma_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int CID_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CLIENTS-1:0]       req_valid,
  output logic [NUM_CLIENTS-1:0]       req_ready,
  input  logic [NUM_CLIENTS-1:0]       req_write,
  input  logic [32*NUM_CLIENTS-1:0]    req_handle,
  input  logic [32*NUM_CLIENTS-1:0]    req_addr,
  input  logic [LEN_W*NUM_CLIENTS-1:0] req_len,
  input  logic [NUM_CLIENTS-1:0]       wdata_valid,
  input  logic [32*NUM_CLIENTS-1:0]    wdata,
  output logic [NUM_CLIENTS-1:0]       wdata_ready,
  output logic                         rdata_valid,
  output logic [31:0]                  rdata,
  output logic [CID_W-1:0]             rdata_client,
  output logic                         rdata_last,
  input  logic                         rdata_ready,
  input  logic                         dma_rdy_readrequest,
  output logic                         dma_en_readrequest,
  output logic [31:0]                  dma_readrequest_addr,
  output logic [31:0]                  dma_readrequest_handle,
  input  logic                         dma_rdy_readresponse,
  output logic                         dma_en_readresponse,
  input  logic [31:0]                  dma_readresponse_data,
  output logic                         dma_en_write32,
  output logic [31:0]                  dma_write32_addr,
  output logic [31:0]                  dma_write32_handle,
  output logic [31:0]                  dma_write32_data,
  output logic                         busy
);

  // Counts hold len+1, so one extra bit covers a full 2^LEN_W-beat burst.
  localparam int CNT_W = LEN_W + 1;

  arb_state_e       state_q, state_d;
  logic [CID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CID_W-1:0] client_q, client_d;
  logic [31:0]      handle_q, handle_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  logic                   grant_valid;
  logic [NUM_CLIENTS-1:0] grant;
  logic [CID_W-1:0]       grant_idx;

  xsim_rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .CID_W      (CID_W)
  ) u_rr (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Next-state and port outputs; reset forces every output low in the same cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    client_d    = client_q;
    handle_d    = handle_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;

    req_ready              = '0;
    wdata_ready            = '0;
    rdata_valid            = 1'b0;
    rdata                  = '0;
    rdata_client           = '0;
    rdata_last             = 1'b0;
    dma_en_readrequest     = 1'b0;
    dma_readrequest_addr   = '0;
    dma_readrequest_handle = '0;
    dma_en_readresponse    = 1'b0;
    dma_en_write32         = 1'b0;
    dma_write32_addr       = '0;
    dma_write32_handle     = '0;
    dma_write32_data       = '0;
    busy                   = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          req_ready   = grant;
          handle_d    = req_handle[grant_idx*32 +: 32];
          addr_d      = req_addr[grant_idx*32 +: 32];
          client_d    = grant_idx;
          rr_ptr_d    = grant_idx;
          issue_cnt_d = CNT_W'(req_len[grant_idx*LEN_W +: LEN_W]) + 1'b1;
          ret_cnt_d   = CNT_W'(req_len[grant_idx*LEN_W +: LEN_W]) + 1'b1;
          state_d     = req_write[grant_idx] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (dma_rdy_readrequest && (issue_cnt_q != '0)) begin
          dma_en_readrequest     = 1'b1;
          dma_readrequest_addr   = addr_q;
          dma_readrequest_handle = handle_q;
          addr_d                 = addr_q + 32'(BEAT_BYTES);
          issue_cnt_d            = issue_cnt_q - 1'b1;
        end
        rdata_valid  = dma_rdy_readresponse;
        rdata        = dma_readresponse_data;
        rdata_client = client_q;
        rdata_last   = (ret_cnt_q == CNT_W'(1));
        if (dma_rdy_readresponse && rdata_ready) begin
          dma_en_readresponse = 1'b1;
          ret_cnt_d           = ret_cnt_q - 1'b1;
          if (ret_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wdata_ready[client_q] = 1'b1;
        if (wdata_valid[client_q]) begin
          dma_en_write32     = 1'b1;
          dma_write32_addr   = addr_q;
          dma_write32_handle = handle_q;
          dma_write32_data   = wdata[client_q*32 +: 32];
          addr_d             = addr_q + 32'(BEAT_BYTES);
          issue_cnt_d        = issue_cnt_q - 1'b1;
          if (issue_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (RST) begin
      req_ready              = '0;
      wdata_ready            = '0;
      rdata_valid            = 1'b0;
      rdata                  = '0;
      rdata_client           = '0;
      rdata_last             = 1'b0;
      dma_en_readrequest     = 1'b0;
      dma_readrequest_addr   = '0;
      dma_readrequest_handle = '0;
      dma_en_readresponse    = 1'b0;
      dma_en_write32         = 1'b0;
      dma_write32_addr       = '0;
      dma_write32_handle     = '0;
      dma_write32_data       = '0;
      busy                   = 1'b0;
    end
  end

  // State registers; reset drops any burst and gives client 0 first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= CID_W'(NUM_CLIENTS - 1);
      client_q    <= '0;
      handle_q    <= '0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      client_q    <= client_d;
      handle_q    <= handle_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

endmodule
